// File: rtl/onchip_ram_wb_ctrl.sv
// -----------------------------------------------------------------------------
// onchip_ram_wb_ctrl
//   Wishbone B3 slave that fronts a single-port synchronous on-chip RAM.
//   Reads are served with one cycle of latency and support incrementing
//   bursts (cti=3'b010), one beat per cycle. Full-word writes go straight to
//   the RAM. Partial writes do a read-modify-write: the old word is read,
//   merged per byte lane and written back. Writes are always single
//   transfers.
//
// Ports
//   inclock      in   system clock, rising edge
//   inaclr_a     in   asynchronous active-high reset
//   wb_adr_i     in   byte address (aw+2 bits, [1:0] ignored)
//   wb_dat_i     in   write data
//   wb_sel_i     in   byte-lane selects
//   wb_we_i      in   write enable
//   wb_cyc_i     in   bus cycle
//   wb_stb_i     in   strobe
//   wb_cti_i     in   cycle type identifier
//   wb_dat_o     out  read data (always the RAM output)
//   wb_ack_o     out  transfer acknowledge
//   ram_address  out  RAM word address
//   ram_data     out  RAM write data
//   ram_we       out  RAM write enable
//   ram_q        in   RAM read data (word addressed at previous edge)
// -----------------------------------------------------------------------------
module onchip_ram_wb_ctrl #(
  parameter int aw = 11,
  parameter int dw = 32
) (
  input  logic          inclock,
  input  logic          inaclr_a,
  input  logic [aw+1:0] wb_adr_i,
  input  logic [dw-1:0] wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic [2:0]    wb_cti_i,
  output logic [dw-1:0] wb_dat_o,
  output logic          wb_ack_o,
  output logic [aw-1:0] ram_address,
  output logic [dw-1:0] ram_data,
  output logic          ram_we,
  input  logic [dw-1:0] ram_q
);

  localparam int lw = dw / 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    RMW  = 2'd2,
    WACK = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [aw-1:0]   wadr_q, wadr_d;
  logic            ack_q, ack_d;
  logic            we_c;
  logic            req;
  logic            full_word;
  logic            burst_go;
  logic [aw-1:0]   adr_word;
  logic [aw-1:0]   wadr_inc;
  logic            unused_adr_lsb;

  // Byte-lane merge: selected lanes from the new word, the rest from the old.
  function automatic logic [dw-1:0] lane_merge(input logic [dw-1:0] old_w,
                                               input logic [dw-1:0] new_w,
                                               input logic [3:0]    sel);
    logic [dw-1:0] m;
    m = old_w;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) begin
        m[i*lw +: lw] = new_w[i*lw +: lw];
      end else begin
        m[i*lw +: lw] = old_w[i*lw +: lw];
      end
    end
    return m;
  endfunction

  assign adr_word       = wb_adr_i[aw+1:2];
  assign unused_adr_lsb = ^wb_adr_i[1:0];
  assign req            = wb_cyc_i & wb_stb_i;
  assign full_word      = (wb_sel_i == 4'hF);
  assign burst_go       = req & (wb_cti_i == 3'b010);
  // Natural wrap at 2^aw gives the burst wrap-around for free.
  assign wadr_inc       = wadr_q + aw'(1'b1);

  assign wb_dat_o = ram_q;
  assign wb_ack_o = ack_q;
  // Reset also blocks the combinational full-write path out of IDLE.
  assign ram_we   = we_c & ~inaclr_a;

  // State, word-address and acknowledge registers.
  always_ff @(posedge inclock or posedge inaclr_a) begin
    if (inaclr_a) begin
      state_q <= IDLE;
      wadr_q  <= {aw{1'b0}};
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wadr_q  <= wadr_d;
      ack_q   <= ack_d;
    end
  end

  // Next-state and word-address update.
  always_comb begin
    state_d = state_q;
    wadr_d  = wadr_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          wadr_d = adr_word;
          if (!wb_we_i) begin
            state_d = RD;
          end else if (full_word) begin
            state_d = WACK;
          end else begin
            state_d = RMW;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD: begin
        if (burst_go) begin
          state_d = RD;
          wadr_d  = wadr_inc;
        end else begin
          state_d = IDLE;
        end
      end
      RMW:     state_d = WACK;
      WACK:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Ack is high exactly in the RD and WACK states.
    ack_d = (state_d == RD) || (state_d == WACK);
  end

  // RAM-side outputs.
  always_comb begin
    ram_address = wadr_q;
    ram_data    = wb_dat_i;
    we_c        = 1'b0;
    case (state_q)
      IDLE: begin
        ram_address = adr_word;
        if (req & wb_we_i & full_word) begin
          we_c = 1'b1;
        end else begin
          we_c = 1'b0;
        end
      end
      RD: begin
        // Present the next word early so it appears on ram_q with the next ack.
        if (burst_go) begin
          ram_address = wadr_inc;
        end else begin
          ram_address = wadr_q;
        end
      end
      RMW: begin
        ram_data = lane_merge(ram_q, wb_dat_i, wb_sel_i);
        we_c     = 1'b1;
      end
      WACK:    ram_address = wadr_q;
      default: we_c = 1'b0;
    endcase
  end

endmodule

// File: doc/onchip_ram_wb_ctrl.md
ONCHIP_RAM_WB_CTRL -- requirements
Module: onchip_ram_wb_ctrl

Interface
REQ-001 The block SHALL have parameter aw, default 11, meaning RAM word-address width.
REQ-002 The block SHALL have parameter dw, default 32, meaning data width (4 byte lanes, fixed).
REQ-003 The block SHALL have port inclock  input  1  system clock, all logic on its rising edge.
REQ-004 The block SHALL have port inaclr_a  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port wb_adr_i  input  aw+2  Wishbone byte address; bits [1:0] are ignored.
REQ-006 The block SHALL have ports wb_dat_i  input  dw, wb_sel_i  input  4, wb_we_i  input  1, wb_cyc_i  input  1, wb_stb_i  input  1, wb_cti_i  input  3, with Wishbone B3 meanings.
REQ-007 The block SHALL have ports wb_dat_o  output  dw  read data, and wb_ack_o  output  1  transfer acknowledge.
REQ-008 The block SHALL have ports ram_address  output  aw, ram_data  output  dw, ram_we  output  1, ram_q  input  dw.
- RAM side: single-port synchronous RAM.
- Address and write are sampled on the inclock edge.
- ram_q = mem[address registered at previous edge].

Function
REQ-009 The block SHALL implement a state machine with states IDLE, RD, RMW, WACK.
REQ-010 IDLE SHALL drive ram_address = wb_adr_i[aw+1:2] combinationally, and SHALL load the internal word-address register wadr with the same value when cyc&stb is high.
REQ-011 In IDLE with cyc&stb&!we, the block SHALL go to RD.
REQ-012 In IDLE with cyc&stb&we&(sel==4'hF), the block SHALL drive ram_we=1 and ram_data=wb_dat_i in the same cycle, then go to WACK.
REQ-013 In IDLE with cyc&stb&we&(sel!=4'hF), the block SHALL go to RMW without writing.
- sel==4'h0 writes are handled identically: the old word is written back unchanged and the transfer is acknowledged.
REQ-014 RD SHALL assert wb_ack_o=1 and drive wb_dat_o=ram_q.
- Read latency: ack in the cycle after the request is first seen in IDLE.
REQ-015 In RD with cyc&stb and wb_cti_i==3'b010, the block SHALL drive ram_address=wadr+1 (modulo 2^aw), load wadr with wadr+1, and stay in RD.
- Result: one ack per cycle, consecutive words.
REQ-016 In RD with wb_cti_i==3'b000 or 3'b111, or with cyc low, the block SHALL return to IDLE.
REQ-017 RMW SHALL drive ram_address=wadr, ram_we=1, and ram_data lane i = wb_sel_i[i] ? wb_dat_i lane i : ram_q lane i, then go to WACK.
REQ-018 WACK SHALL assert wb_ack_o=1 for exactly one cycle and return to IDLE.
REQ-019 Writes SHALL always be single (classic) transfers.
- A write request with cti==3'b010 is handled as a classic write, one ack per request.
REQ-020 wb_ack_o SHALL be 0 in IDLE and RMW.
REQ-021 ram_we SHALL be 0 in all cases other than REQ-012 and REQ-017.
REQ-022 If cyc drops in RMW, the merged write SHALL still complete, and WACK SHALL still pulse ack once.
- The master ignores this ack.
REQ-023 A burst SHALL wrap from word address 2^aw-1 to 0 without an error indication.
REQ-024 wb_dat_o SHALL equal ram_q in every state.
- It is only meaningful while wb_ack_o=1 in RD.

Reset
REQ-025 While inaclr_a=1, the following SHALL hold asynchronously:
- state=IDLE, wadr=0, wb_ack_o=0, ram_we=0.
REQ-026 After reset deassertion, the block SHALL accept a request in the first IDLE cycle.
REQ-027 Reset asserted mid-burst or mid-RMW SHALL abort the transfer.
- No further ack is issued.
- No RAM write occurs after reset assertion.

Verification
REQ-028 Classic read: preload mem[5]=0x11223344; read adr=0x14 -> ack one cycle later with dat_o=0x11223344; next request accepted after return to IDLE.
REQ-029 Full write: write 0xDEADBEEF, sel=F, adr=0x20 -> ram_we in the request cycle, ack next cycle; readback of mem[8]=0xDEADBEEF.
REQ-030 Byte write: mem[8]=0xDEADBEEF; write 0x000000AA, sel=4'b0001 -> ack 2 cycles after request; mem[8]=0xDEADBEAA.
REQ-031 Burst read: cti=010 from word 2^aw-2 for 4 beats, final beat cti=111 -> 4 consecutive acks; data from words 2^aw-2, 2^aw-1, 0, 1; then IDLE.
REQ-032 Reset mid-burst: assert inaclr_a during the beat-2 ack -> wb_ack_o=0 immediately; no ram_we; idle after release.
REQ-033 Abort: cyc drops during a burst read -> no further ack; next request served normally.
